vedic_multiplier_8bit: RTL and testbench
========================================

// Module: vedic_multiplier_8bit
// PURPOSE
//  Registered 8x8 unsigned multiplier using the Vedic (Urdhva-Tiryagbhyam) hierarchy:
//  2x2 cells form 4x4 blocks, and four 4x4 blocks form the 8x8 product.
//  Serves as the element multiplier of the matrix-multiplier datapath.
//  One product is accepted per clock, with a one-cycle result latency.
// PARAMETERS
//  DATA_WIDTH  8  operand width; only 8 is supported; any other value must fail elaboration
// PORTS
//  clk         in   1    single clock; all state updates on the rising edge
//  rst         in   1    synchronous, active-high reset
//  inValid     in   1    operands on inData_A/inData_B are valid this cycle
//  inData_A    in   8    multiplicand, unsigned
//  inData_B    in   8    multiplier, unsigned
//  outValid    out  1    outData_C holds a new product
//  outData_C   out  16   product A*B, unsigned, registered
// BEHAVIOUR
//  - Reset: while rst=1 at a clock edge, outData_C<=16'h0000 and outValid<=0; inputs ignored.
//  - Latency 1: when inValid=1 at edge N, outData_C=A*B and outValid=1 after edge N.
//  - inValid=0 at an edge: outValid<=0 and outData_C holds its last value (no update).
//  - No back-pressure. A new operand pair may arrive every cycle (full throughput).
//  - Arithmetic: exact unsigned product. Intermediate sums use full width, so there is
//    no overflow and no truncation. Maximum result is 255*255=65025 (16'hFE01).
//  - 2x2 cell (a,b -> q[3:0]): q0=a0&b0; HA(a1&b0, a0&b1) -> q1, c1; HA(a1&b1, c1) -> q2, q3.
//  - 4x4 block: four 2x2 products p0=aL*bL, p1=aH*bL, p2=aL*bH, p3=aH*bH.
//    q[1:0]=p0[1:0]; s=p1+p2+{2'b0,p0[3:2]}; q[3:2]=s[1:0];
//    q[7:4]=p3+s[5:2] (4-bit result, no carry-out possible).
//  - 8x8: the same scheme with four 4x4 blocks, 4-bit split, 8-bit partials, 16-bit result.
//  - Combinational core feeds only the output register. The core has no internal pipeline state.
//  - Reset asserted in the same cycle as inValid: reset wins and the operand is dropped.
//  - X on inData while inValid=0 must not propagate to outData_C.
// STRUCTURE
//  - Shared package vedic_pkg: localparam VEDIC_W=8, PROD_W=2*VEDIC_W; typedef
//    logic [VEDIC_W-1:0] vop_t, logic [PROD_W-1:0] vprod_t.
//  - Sub-module vedic_mul_4bit: combinational 4x4 block containing four inline 2x2 cells
//    and its adders. The top instantiates it four times, adds the 8x8 recombination
//    adders, and holds the output/valid registers.
// TESTING
//  - rst=1 for 2 cycles with inValid=1, A=8'hFF, B=8'hFF
//    -> outData_C=0 and outValid=0 throughout.
//  - A=255, B=255, inValid=1 -> next cycle outData_C=65025 and outValid=1.
//  - A=0, B=173 then A=1, B=173 on back-to-back cycles -> 0 then 173, outValid=1 both cycles.
//  - Corner-of-sub-block values: A=3, B=3 -> 9; A=15, B=15 -> 225; A=16, B=16 -> 256;
//    A=240, B=15 -> 3600.
//  - inValid drops after A=12, B=11 -> product 132 stays on outData_C and outValid=0
//    on the following cycle.
//  - 10,000 random A,B in 0..255 with random inValid gaps -> every product equals the
//    A*B reference; also assert rst mid-stream and confirm the register is cleared.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared widths and operand/product types for the Vedic multiplier slice.
package vedic_pkg;
   localparam int VEDIC_W = 8;
   localparam int PROD_W  = 2 * VEDIC_W;

   typedef logic [VEDIC_W-1:0] vop_t;
   typedef logic [PROD_W-1:0]  vprod_t;
endpackage

// File: rtl/vedic_mul_4bit.sv
// Combinational 4x4 Urdhva-Tiryagbhyam block built from four 2x2 cells.
module vedic_mul_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] q_o
);
   // 2x2 cell: one AND for bit 0, then two half adders.
   function automatic logic [3:0] mul2(input logic [1:0] a, input logic [1:0] b);
      logic       c1;
      logic [3:0] q;
      q[0] = a[0] & b[0];
      q[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
      c1   = (a[1] & b[0]) & (a[0] & b[1]);
      q[2] = (a[1] & b[1]) ^ c1;
      q[3] = (a[1] & b[1]) & c1;
      return q;
   endfunction

   logic [3:0] p0, p1, p2, p3;
   logic [5:0] s;

   always_comb begin
      p0 = mul2(a_i[1:0], b_i[1:0]);
      p1 = mul2(a_i[3:2], b_i[1:0]);
      p2 = mul2(a_i[1:0], b_i[3:2]);
      p3 = mul2(a_i[3:2], b_i[3:2]);
      s  = {2'b00, p1} + {2'b00, p2} + {4'b0000, p0[3:2]};
      // Upper nibble sum is self-determined 4 bits; the product cannot exceed 8 bits.
      q_o = {p3 + s[5:2], s[1:0], p0[1:0]};
   end
endmodule

// File: rtl/vedic_multiplier_8bit.sv
// Registered 8x8 unsigned Vedic multiplier: four 4x4 blocks plus recombination adders.
module vedic_multiplier_8bit
   import vedic_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inValid,
   input  logic [7:0]  inData_A,
   input  logic [7:0]  inData_B,
   output logic        outValid,
   output logic [15:0] outData_C
);
   if (DATA_WIDTH != VEDIC_W) begin : g_bad_width
      $error("vedic_multiplier_8bit supports DATA_WIDTH=8 only");
   end

   logic [7:0]  p0, p1, p2, p3;
   logic [11:0] s;
   vprod_t      prod_d, prod_q;
   logic        vld_q;

   vedic_mul_4bit u_ll (.a_i(inData_A[3:0]), .b_i(inData_B[3:0]), .q_o(p0));
   vedic_mul_4bit u_hl (.a_i(inData_A[7:4]), .b_i(inData_B[3:0]), .q_o(p1));
   vedic_mul_4bit u_lh (.a_i(inData_A[3:0]), .b_i(inData_B[7:4]), .q_o(p2));
   vedic_mul_4bit u_hh (.a_i(inData_A[7:4]), .b_i(inData_B[7:4]), .q_o(p3));

   always_comb begin
      s      = {4'h0, p1} + {4'h0, p2} + {8'h00, p0[7:4]};
      prod_d = {p3 + s[11:4], s[3:0], p0[3:0]};
   end

   // Product register only loads on valid, so idle-cycle operands never reach the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= inValid;
         if (inValid) prod_q <= prod_d;
      end
   end

   assign outData_C = prod_q;
   assign outValid  = vld_q;
endmodule

// File: tb/tb_vedic_multiplier_8bit.sv
// Directed and random self-checking bench for vedic_multiplier_8bit.
module tb_vedic_multiplier_8bit;
   logic        clk = 1'b0;
   logic        rst;
   logic        inValid;
   logic [7:0]  inData_A, inData_B;
   logic        outValid;
   logic [15:0] outData_C;

   int checks = 0;
   int errors = 0;

   vedic_multiplier_8bit #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .inValid(inValid),
      .inData_A(inData_A), .inData_B(inData_B),
      .outValid(outValid), .outData_C(outData_C)
   );

   always #5 clk = ~clk;

   // Apply inputs on the falling edge, step through a rising edge, settle before sampling.
   task automatic drive(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      rst = r; inValid = v; inData_A = a; inData_B = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 8'hFF, 8'hFF);
         checks++;
         if (outData_C !== 16'h0000 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL reset cyc%0d: got C=%h V=%b want C=0000 V=0", i, outData_C, outValid);
         end
      end
   endtask

   task automatic test_max;
      drive(1'b0, 1'b1, 8'd255, 8'd255);
      checks++;
      if (outData_C !== 16'd65025 || outValid !== 1'b1) begin
         errors++;
         $display("FAIL max: got C=%0d V=%b want C=65025 V=1", outData_C, outValid);
      end
   endtask

   task automatic test_back_to_back;
      drive(1'b0, 1'b1, 8'd0, 8'd173);
      checks++;
      if (outData_C !== 16'd0 || outValid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_zero: got C=%0d V=%b want C=0 V=1", outData_C, outValid);
      end
      drive(1'b0, 1'b1, 8'd1, 8'd173);
      checks++;
      if (outData_C !== 16'd173 || outValid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_one: got C=%0d V=%b want C=173 V=1", outData_C, outValid);
      end
   endtask

   task automatic test_corners;
      logic [7:0]  av [4] = '{8'd3, 8'd15, 8'd16, 8'd240};
      logic [7:0]  bv [4] = '{8'd3, 8'd15, 8'd16, 8'd15};
      logic [15:0] ev [4] = '{16'd9, 16'd225, 16'd256, 16'd3600};
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, av[i], bv[i]);
         checks++;
         if (outData_C !== ev[i] || outValid !== 1'b1) begin
            errors++;
            $display("FAIL corner %0d*%0d: got C=%0d V=%b want C=%0d V=1",
                     av[i], bv[i], outData_C, outValid, ev[i]);
         end
      end
   endtask

   task automatic test_hold;
      drive(1'b0, 1'b1, 8'd12, 8'd11);
      checks++;
      if (outData_C !== 16'd132 || outValid !== 1'b1) begin
         errors++;
         $display("FAIL hold_load: got C=%0d V=%b want C=132 V=1", outData_C, outValid);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 8'hxx, 8'hxx);
         checks++;
         if (outData_C !== 16'd132 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle%0d: got C=%0d V=%b want C=132 V=0", i, outData_C, outValid);
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] exp_c = 16'd132;
      logic        exp_v;
      logic        r, v;
      logic [7:0]  a, b;
      for (int i = 0; i < 10000; i++) begin
         r = (i == 5000) || (i == 5001);
         v = ($urandom_range(3, 0) != 0);
         a = 8'($urandom_range(255, 0));
         b = 8'($urandom_range(255, 0));
         drive(r, v, a, b);
         if (r) begin
            exp_c = 16'h0000; exp_v = 1'b0;
         end else begin
            exp_v = v;
            if (v) exp_c = 16'(a) * 16'(b);
         end
         checks++;
         if (outData_C !== exp_c || outValid !== exp_v) begin
            errors++;
            $display("FAIL random i=%0d A=%0d B=%0d rst=%b: got C=%0d V=%b want C=%0d V=%b",
                     i, a, b, r, outData_C, outValid, exp_c, exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1; inValid = 1'b0; inData_A = '0; inData_B = '0;
      test_reset();
      test_max();
      test_back_to_back();
      test_corners();
      test_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
